dff_share_arbiter: RTL and testbench
====================================

// Module: dff_share_arbiter
// PURPOSE
//  Round-robin write arbiter for a shared WIDTH-bit D-flip-flop register.
//  Up to NUM_REQ requesters present write data with a req line; the block picks
//  one winner per cycle, loads its data into the shared register and returns a
//  one-cycle grant pulse. Sits between requester logic and the shared storage bank.
// PARAMETERS
//  NUM_REQ  4  number of requesters, >= 2
//  WIDTH    8  shared register / write data width
//  IDXW     $clog2(NUM_REQ)  requester index width (derived, not overridden)
// PORTS
//  clk    in   1                rising-edge clock, single clock domain
//  rst    in   1                asynchronous, active-high reset
//  req    in   NUM_REQ          write request, bit i = requester i; level, held until gnt
//  wdata  in   NUM_REQ*WIDTH    packed write data, slice [i*WIDTH +: WIDTH] = requester i
//  gnt    out  NUM_REQ          registered one-hot grant pulse, high one cycle per write
//  q      out  WIDTH            shared register contents
//  q_vld  out  1                high once the register has been written since reset
//  owner  out  IDXW             index of the last requester that wrote q
//  busy   out  1                high in state GRANT
// BEHAVIOUR
//  Reset (async, any time): gnt=0, q=0, q_vld=0, owner=0, busy=0, rr_ptr=0, state=IDLE.
//  Eligibility each cycle: elig = req & ~gnt (a requester whose gnt is high this cycle is masked).
//  Winner: first set bit of elig searching rr_ptr, rr_ptr+1, ... wrapping NUM_REQ-1 -> 0.
//  On rising edge, if elig != 0 (winner w):
//   - q <= wdata[w], owner <= w, q_vld <= 1, gnt <= one-hot(w),
//   - rr_ptr <= (w == NUM_REQ-1) ? 0 : w+1, state <= GRANT.
//  On rising edge, if elig == 0: gnt <= 0, q/owner/q_vld/rr_ptr unchanged, state <= IDLE.
//  Latency: req asserted before edge k (and winning) -> q updated and gnt high in cycle k+1.
//  FSM: IDLE --elig!=0--> GRANT; GRANT --elig!=0--> GRANT (back-to-back, different requester);
//   GRANT --elig==0--> IDLE. busy = (state == GRANT). Exactly one write per GRANT cycle.
//  Requester protocol: drop req in the cycle gnt is seen, or it is re-arbitrated the
//   following cycle (fair: rr_ptr has already moved past it).
//  Only one requester active: granted every other cycle at most (mask on its gnt cycle).
//  wdata of non-winning requesters is ignored; X on non-winning slices must not reach q.
//  Fairness: any continuously requesting requester is granted within NUM_REQ grants.
//  rst asserted in GRANT: gnt drops immediately (async), write in progress is not completed.
//  No combinational path from req/wdata to any output; all outputs registered.
// TESTING
//  1 Reset: assert rst mid-sim with req=4'b1111 -> gnt=0, q=0, q_vld=0, owner=0 instantly.
//  2 Single write: req=4'b0100, wdata[2]=8'hA5 one cycle -> next cycle gnt=4'b0100,
//    q=8'hA5, owner=2, q_vld=1; following cycle gnt=0, busy=0.
//  3 Round robin: req=4'b1111 held, distinct data -> grants 0,1,2,3,0 on consecutive
//    cycles, q tracks matching wdata each cycle, busy stays 1.
//  4 Wrap pointer: after grant to 3, req=4'b1001 -> grant 0 next, then 3.
//  5 Masking: req=4'b0001 held continuously -> gnt toggles 0001,0000,0001,...;
//    q rewritten only on gnt cycles.
//  6 Async reset during GRANT: rst pulse mid-cycle while gnt=4'b0010 -> gnt=0 before
//    next edge; after release with req=4'b0010 -> requester 1 granted from rr_ptr=0.

Source files
------------

// File: rtl/dff_share_arbiter.sv
// -----------------------------------------------------------------------------
// dff_share_arbiter
//
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// Each cycle the eligible requesters are scanned starting at the round-robin
// pointer. The winner's data is loaded into the shared register and the winner
// gets a one-cycle grant pulse.
//
// Ports:
//   clk    in   1              rising-edge clock
//   rst    in   1              asynchronous active-high reset
//   req    in   NUM_REQ        level write requests, bit i = requester i
//   wdata  in   NUM_REQ*WIDTH  packed write data, slice i = requester i
//   gnt    out  NUM_REQ        registered one-hot grant pulse
//   q      out  WIDTH          shared register contents
//   q_vld  out  1              register written at least once since reset
//   owner  out  IDXW           index of the requester that last wrote q
//   busy   out  1              high while the FSM is in GRANT
// -----------------------------------------------------------------------------
module dff_share_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_vld,
  output logic [IDXW-1:0]          owner,
  output logic                     busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                vld_q, vld_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  elig_s;
  logic                win_found_s;
  logic [IDXW-1:0]     win_idx_s;

  // Winner search: first eligible requester at or after rr_ptr, wrapping.
  // The requester currently holding gnt is masked so it cannot win twice in a row.
  always_comb begin
    int cand;
    cand        = 0;
    elig_s      = req & ~gnt_q;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!win_found_s && elig_s[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDXW'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic of the IDLE/GRANT FSM.
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    data_d   = data_q;
    vld_d    = vld_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    busy_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_GRANT: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
          busy_d  = 1'b1;
          gnt_d   = NUM_REQ'(1'b1) << win_idx_s;
          // Only the winner's slice is selected, so other slices never reach q.
          data_d  = wdata[int'(win_idx_s)*WIDTH +: WIDTH];
          vld_d   = 1'b1;
          owner_d = win_idx_s;
          if (win_idx_s == IDXW'(NUM_REQ-1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = win_idx_s + IDXW'(1'b1);
          end
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign q     = data_q;
  assign q_vld = vld_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
module tb_dff_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         q;
  logic                     q_vld;
  logic [1:0]               owner;
  logic                     busy;

  int total;
  int passed;

  // reference model state
  int               m_ptr;
  logic [3:0]       m_gnt;
  logic [WIDTH-1:0] m_q;
  logic             m_vld;
  logic [1:0]       m_owner;
  logic             m_busy;

  dff_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .q_vld (q_vld),
    .owner (owner),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_ptr   = 0;
    m_gnt   = 4'b0000;
    m_q     = 8'h00;
    m_vld   = 1'b0;
    m_owner = 2'd0;
    m_busy  = 1'b0;
  endtask

  // One clock of the arbitration rule, from the current inputs.
  task automatic model_step();
    logic [3:0] elig;
    int w;
    int idx;
    elig = req & ~m_gnt;
    w = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (w < 0 && elig[idx]) w = idx;
    end
    if (w >= 0) begin
      m_q     = wdata[w*WIDTH +: WIDTH];
      m_owner = 2'(w);
      m_vld   = 1'b1;
      m_gnt   = 4'b0001 << w;
      m_ptr   = (w + 1) % NUM_REQ;
      m_busy  = 1'b1;
    end else begin
      m_gnt  = 4'b0000;
      m_busy = 1'b0;
    end
  endtask

  // Advance one clock; afterwards we sit 1 time unit past the rising edge.
  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req = 4'b0000;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic randomize_wdata();
    for (int i = 0; i < NUM_REQ; i++) wdata[i*WIDTH +: WIDTH] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    total++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_vld !== 1'b0 || owner !== 2'd0 || busy !== 1'b0) begin
      $display("FAIL reset_init: gnt=%b q=%h vld=%b owner=%0d busy=%b, want all zero", gnt, q, q_vld, owner, busy);
    end else passed++;
    // get some state going, then reset mid-cycle with everything requesting
    req = 4'b1111;
    randomize_wdata();
    advance();
    advance();
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_vld !== 1'b0 || owner !== 2'd0 || busy !== 1'b0) begin
      $display("FAIL reset_async: gnt=%b q=%h vld=%b owner=%0d busy=%b, want all zero", gnt, q, q_vld, owner, busy);
    end else passed++;
    rst = 1'b0;
    req = 4'b0000;
    model_reset();
  endtask

  task automatic test_single_write();
    pulse_reset();
    req = 4'b0100;
    wdata = 'x;
    wdata[2*WIDTH +: WIDTH] = 8'hA5;
    advance();
    total++;
    if (gnt !== 4'b0100 || q !== 8'hA5 || owner !== 2'd2 || q_vld !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL single_write: gnt=%b q=%h owner=%0d vld=%b busy=%b, want 0100 a5 2 1 1", gnt, q, owner, q_vld, busy);
    end else passed++;
    req = 4'b0000;
    randomize_wdata();
    advance();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'hA5 || q_vld !== 1'b1) begin
      $display("FAIL single_after: gnt=%b busy=%b q=%h vld=%b, want 0000 0 a5 1", gnt, busy, q, q_vld);
    end else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [WIDTH-1:0] exp_d;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pulse_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      randomize_wdata();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_g[c][i]) exp_d = wdata[i*WIDTH +: WIDTH];
      end
      advance();
      total++;
      if (gnt !== exp_g[c] || q !== exp_d || busy !== 1'b1) begin
        $display("FAIL round_robin[%0d]: gnt=%b q=%h busy=%b, want %b %h 1", c, gnt, q, busy, exp_g[c], exp_d);
      end else passed++;
    end
  endtask

  task automatic test_wrap_pointer();
    pulse_reset();
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      randomize_wdata();
      advance();
    end
    total++;
    if (gnt !== 4'b1000) begin
      $display("FAIL wrap_pre: gnt=%b, want 1000", gnt);
    end else passed++;
    req = 4'b1001;
    advance();
    total++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      $display("FAIL wrap_first: gnt=%b owner=%0d, want 0001 0", gnt, owner);
    end else passed++;
    advance();
    total++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      $display("FAIL wrap_second: gnt=%b owner=%0d, want 1000 3", gnt, owner);
    end else passed++;
  endtask

  task automatic test_masking();
    logic [WIDTH-1:0] last;
    pulse_reset();
    req = 4'b0001;
    last = 8'h00;
    for (int c = 0; c < 6; c++) begin
      randomize_wdata();
      if (c % 2 == 0) last = wdata[WIDTH-1:0];
      advance();
      total++;
      if (gnt !== ((c % 2 == 0) ? 4'b0001 : 4'b0000) || q !== last) begin
        $display("FAIL masking[%0d]: gnt=%b q=%h, want %b %h", c, gnt, q,
                 ((c % 2 == 0) ? 4'b0001 : 4'b0000), last);
      end else passed++;
    end
  endtask

  task automatic test_async_grant();
    pulse_reset();
    // move the pointer away from 0 first
    req = 4'b0001;
    randomize_wdata();
    advance();
    req = 4'b0010;
    advance();
    total++;
    if (gnt !== 4'b0010) begin
      $display("FAIL async_pre: gnt=%b, want 0010", gnt);
    end else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q_vld !== 1'b0) begin
      $display("FAIL async_drop: gnt=%b busy=%b vld=%b, want 0000 0 0", gnt, busy, q_vld);
    end else passed++;
    rst = 1'b0;
    model_reset();
    advance();
    total++;
    if (gnt !== 4'b0010 || owner !== 2'd1 || q !== wdata[WIDTH +: WIDTH]) begin
      $display("FAIL async_regrant: gnt=%b owner=%0d q=%h, want 0010 1 %h", gnt, owner, q, wdata[WIDTH +: WIDTH]);
    end else passed++;
  endtask

  task automatic test_random();
    int since [NUM_REQ];
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) since[i] = 0;
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom_range(0, 15));
      randomize_wdata();
      advance();
      total++;
      if (gnt !== m_gnt || q !== m_q || q_vld !== m_vld || owner !== m_owner || busy !== m_busy) begin
        $display("FAIL random[%0d]: gnt=%b q=%h vld=%b owner=%0d busy=%b, want %b %h %b %0d %b",
                 c, gnt, q, q_vld, owner, busy, m_gnt, m_q, m_vld, m_owner, m_busy);
      end else passed++;
    end
    // fairness: everyone held requesting is granted within NUM_REQ grants
    req = 4'b1111;
    for (int c = 0; c < 4 * NUM_REQ; c++) begin
      advance();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) since[i] = 0;
        else if (|gnt) since[i]++;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      total++;
      if (since[i] >= NUM_REQ) begin
        $display("FAIL fairness[%0d]: grants waited=%0d, want < %0d", i, since[i], NUM_REQ);
      end else passed++;
    end
    req = 4'b0000;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    req    = 4'b0000;
    wdata  = '0;
    rst    = 1'b1;
    model_reset();
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_wrap_pointer();
    test_masking();
    test_async_grant();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
